// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module  : serial_adder_pkg
// Brief   : Shared FSM state encoding and default operand width for serial_adder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_adder_fa_cell.sv
// ============================================================================
// Module  : fa_cell
// Brief   : One-bit combinational full adder used by the bit-serial datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module  : serial_adder
// Brief   : Bit-serial a + b + cin, LSB first, one bit per clock through one fa_cell.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
            $error("serial_adder: WIDTH must be within 2..32");
        end
    endgenerate

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_s;
    logic               w_co;
    logic [c_cnt_w-1:0] w_cnt_nxt;

    fa_cell u_fa (
        .a  (r_a_sr[0]),
        .b  (r_b_sr[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    assign w_cnt_nxt = r_cnt + c_cnt_w'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_carry <= cin;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_a_sr  <= r_a_sr >> 1;
                    r_b_sr  <= r_b_sr >> 1;
                    // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_carry <= w_co;
                    r_cnt   <= w_cnt_nxt;
                    if (w_cnt_nxt == c_cnt_last) begin
                        r_cout  <= w_co;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module  : tb_serial_adder
// Brief   : Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start16;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        cin8, cin16;
    logic        busy8, done8, cout8;
    logic        busy16, done16, cout16;
    logic [7:0]  sum8;
    logic [15:0] sum16;

    int checks   = 0;
    int failures = 0;
    int n_done8  = 0;
    int n_done16 = 0;

    logic [8:0]  q8[$];
    logic [16:0] q16[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboards: each done pulse pops the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            n_done8++;
            if (q8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done8_unexpected got=done exp=no_done at %0t", $time);
            end else begin
                chk("result8", {23'b0, cout8, sum8}, {23'b0, q8.pop_front()});
            end
        end
        if (done16 === 1'b1) begin
            n_done16++;
            if (q16.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done16_unexpected got=done exp=no_done at %0t", $time);
            end else begin
                chk("result16", {15'b0, cout16, sum16}, {15'b0, q16.pop_front()});
            end
        end
    end

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [8:0] exp);
        int cyc;
        int bc;
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        q8.push_back(exp);
        @(negedge clk);
        start8 = 1'b0;
        a8 = ~a; b8 = ~b; cin8 = ~c;
        cyc = 1;
        bc  = 0;
        while (done8 !== 1'b1 && cyc < 40) begin
            if (busy8) bc++;
            @(negedge clk);
            cyc++;
        end
        if (busy8) bc++;
        chk("latency8", cyc, 9);
        chk("busy8_cycles", bc, 9);
        @(negedge clk);
        chk("idle_after8", {30'b0, busy8, done8}, 32'd0);
        chk("hold8", {23'b0, cout8, sum8}, {23'b0, exp});
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c);
        int cyc;
        @(negedge clk);
        a16 = a; b16 = b; cin16 = c; start16 = 1'b1;
        q16.push_back({1'b0, a} + {1'b0, b} + {16'b0, c});
        @(negedge clk);
        start16 = 1'b0;
        a16 = ~a; b16 = ~b; cin16 = ~c;
        cyc = 1;
        while (done16 !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency16", cyc, 17);
        @(negedge clk);
    endtask

    initial begin
        int nd;
        int base;
        logic [7:0] ra, rb;
        logic       rc;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
        vecs[8] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy8", {31'b0, busy8}, 32'd0);
        chk("reset_done8", {31'b0, done8}, 32'd0);
        chk("reset_res8", {23'b0, cout8, sum8}, 32'd0);
        chk("reset_res16", {15'b0, cout16, sum16}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {30'b0, busy8, busy16}, 32'd0);

        foreach (vecs[i])
            run8(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].exp_cout, vecs[i].exp_sum});

        // Start during SHIFT and during DONE must both be dropped.
        base = n_done8;
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(9'h096);
        @(negedge clk); start8 = 1'b0;
        @(negedge clk);
        @(negedge clk); a8 = 8'h11; b8 = 8'h22; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        nd = 0;
        while (done8 !== 1'b1 && nd < 40) begin
            @(negedge clk);
            nd++;
        end
        start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        repeat (15) @(negedge clk);
        chk("ignore_done_count", n_done8 - base, 1);
        chk("ignore_q_empty", q8.size(), 0);
        chk("ignore_hold", {23'b0, cout8, sum8}, 32'h096);

        // Reset mid-operation abandons the addition.
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        repeat (3) @(negedge clk);
        base = n_done8;
        rst = 1'b1;
        #1;
        chk("rst_mid_res", {23'b0, cout8, sum8}, 32'd0);
        chk("rst_mid_busy", {31'b0, busy8}, 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("rst_mid_no_done", n_done8 - base, 0);
        run8(8'h01, 8'h01, 1'b0, 9'h002);

        // Back-to-back with start held high; operands scrambled mid-operation.
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        repeat (3) q8.push_back(9'h010);
        nd = 0;
        for (int c = 1; c <= 29; c++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin
                nd++;
                chk("b2b_phase", c % 10, 9);
            end
            if (c % 10 >= 2 && c % 10 <= 7) begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            end else begin
                a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0;
            end
            if (c == 29) start8 = 1'b0;
        end
        chk("b2b_count", nd, 3);
        repeat (15) @(negedge clk);
        chk("b2b_q_empty", q8.size(), 0);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            run8(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'b0, rc});
        end
        for (int i = 0; i < 1000; i++)
            run16(16'($urandom), 16'($urandom), 1'($urandom));
        run16(16'hFFFF, 16'h0000, 1'b1);

        repeat (5) @(negedge clk);
        chk("final_q8_empty", q8.size(), 0);
        chk("final_q16_empty", q16.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
